// File: rtl/fnv_pkg.sv
// Shared constants, types and helpers for the FNV hash engine.
package fnv_pkg;

  localparam logic [31:0] FNV32_OFFSET = 32'h811C_9DC5;
  localparam logic [31:0] FNV32_PRIME  = 32'h0100_0193;
  localparam logic [63:0] FNV64_OFFSET = 64'hCBF2_9CE4_8422_2325;
  localparam logic [63:0] FNV64_PRIME  = 64'h0000_0100_0000_01B3;

  typedef enum logic {FNV1, FNV1A} fnv_variant_e;

  typedef enum logic [1:0] {IDLE, MUL, DONE} fnv_state_e;

  // Constants come back zero-extended to 64 bits; callers slice to their width.
  function automatic logic [63:0] fnv_offset(input int w);
    return (w == 64) ? FNV64_OFFSET : {32'h0, FNV32_OFFSET};
  endfunction

  function automatic logic [63:0] fnv_prime(input int w);
    return (w == 64) ? FNV64_PRIME : {32'h0, FNV32_PRIME};
  endfunction

endpackage

// File: rtl/fnv_hasher_if.sv
// Byte-stream input and digest output handshake of the FNV engine.
// Carries out_fold only when FNV_XOR_FOLD_EN is defined.
interface fnv_hasher_if #(
  parameter int HASH_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_hash;
  logic [CNT_W-1:0]  out_count;
  logic              busy;
`ifdef FNV_XOR_FOLD_EN
  logic [HASH_W/2-1:0] out_fold;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_hash, out_count, busy, out_fold
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_hash, out_count, busy, out_fold
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_hash, out_count, busy
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_hash, out_count, busy
  );
`endif
endinterface

// File: rtl/fnv_prime_mul.sv
// Iterative modular multiply by the FNV prime, one prime byte per cycle.
// done is high during the last step; product is the finished value then.
module fnv_prime_mul
  import fnv_pkg::*;
#(
  parameter int HASH_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HASH_W-1:0] x,
  output logic              done,
  output logic [HASH_W-1:0] product
);

  localparam int S   = HASH_W / 8;
  localparam int K_W = $clog2(S);
  localparam logic [63:0]       PRIME64 = fnv_prime(HASH_W);
  localparam logic [HASH_W-1:0] PRIME   = PRIME64[HASH_W-1:0];

  logic              run;
  logic [K_W-1:0]    k;
  logic [HASH_W-1:0] x_r;
  logic [HASH_W-1:0] acc;
  logic [HASH_W-1:0] part;
  logic [HASH_W-1:0] acc_next;
  logic [7:0]        prime_byte;

  // Partial product of x with prime byte k, placed at byte offset k.
  always_comb begin
    prime_byte = PRIME[{k, 3'b000} +: 8];
    part       = (x_r * {{(HASH_W-8){1'b0}}, prime_byte}) << {k, 3'b000};
    acc_next   = acc + part;
  end

  assign done    = run && (k == K_W'(S - 1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      k   <= '0;
      x_r <= '0;
      acc <= '0;
    end else if (start) begin
      run <= 1'b1;
      k   <= '0;
      x_r <= x;
      acc <= '0;
    end else if (run) begin
      acc <= acc_next;
      k   <= k + K_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fnv_hasher.sv
// Stream-fed FNV-1/FNV-1a engine, 32 or 64 bit, with held digest handshake.
// Optional out_fold XOR-folded digest when FNV_XOR_FOLD_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a byte, hash holds running value
//   MUL   | prime multiply in progress (S cycles), input stalled
//   DONE  | digest held on out_hash/out_count until out_ready
module fnv_hasher
  import fnv_pkg::*;
#(
  parameter int HASH_W  = 32,
  parameter int VARIANT = 1,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  fnv_hasher_if.slave bus
);

  if (!(HASH_W == 32 || HASH_W == 64)) begin : g_bad_width
    $error("fnv_hasher: HASH_W must be 32 or 64");
  end

  localparam logic [63:0]       OFFSET64 = fnv_offset(HASH_W);
  localparam logic [HASH_W-1:0] OFFSET   = OFFSET64[HASH_W-1:0];
  localparam bit                IS_1A    = (VARIANT == int'(FNV1A));

  fnv_state_e        state, state_n;
  logic [HASH_W-1:0] hash;
  logic [CNT_W-1:0]  count;
  logic [7:0]        byte_r;
  logic              last_r;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              mul_done;
  logic [HASH_W-1:0] mul_x;
  logic [HASH_W-1:0] mul_p;
  logic [HASH_W-1:0] result;

  assign accept = bus.in_valid && in_ready;
  assign mul_x  = IS_1A ? (hash ^ HASH_W'(bus.in_data)) : hash;
  assign result = IS_1A ? mul_p : (mul_p ^ HASH_W'(byte_r));

  fnv_prime_mul #(.HASH_W(HASH_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .x       (mul_x),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = MUL;
      end
      MUL: begin
        if (mul_done) state_n = last_r ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hash   <= OFFSET;
      count  <= '0;
      byte_r <= '0;
      last_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        byte_r <= bus.in_data;
        last_r <= bus.in_last;
        if (!(&count)) count <= count + CNT_W'(1);
      end
      if (state == MUL && mul_done) hash <= result;
      if (state == DONE && bus.out_ready) begin
        hash  <= OFFSET;
        count <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_hash  = hash;
  assign bus.out_count = count;
  assign bus.busy      = (state != IDLE);
`ifdef FNV_XOR_FOLD_EN
  assign bus.out_fold  = hash[HASH_W-1:HASH_W/2] ^ hash[HASH_W/2-1:0];
`endif

endmodule

// File: tb/tb_fnv_hasher.sv
// Self-checking bench for fnv_hasher: table of FNV-1a-32 messages on a main
// instance, plus single-byte checks on FNV-1 / 64-bit instances.
module tb_fnv_hasher;
  import fnv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main instance: 32-bit FNV-1a with a narrow counter so saturation is reachable.
  fnv_hasher_if #(.HASH_W(32), .CNT_W(4)) bus ();
  fnv_hasher #(.HASH_W(32), .VARIANT(1), .CNT_W(4)) dut (
    .clk (clk), .reset (reset), .bus (bus.slave));

  // Side instances share one single-byte stimulus.
  logic       sv, sr;
  fnv_hasher_if #(.HASH_W(32), .CNT_W(16)) b0 ();
  fnv_hasher_if #(.HASH_W(64), .CNT_W(16)) b1 ();
  fnv_hasher_if #(.HASH_W(64), .CNT_W(16)) b2 ();
  fnv_hasher #(.HASH_W(32), .VARIANT(0), .CNT_W(16)) dut_s0 (.clk (clk), .reset (reset), .bus (b0.slave));
  fnv_hasher #(.HASH_W(64), .VARIANT(1), .CNT_W(16)) dut_s1 (.clk (clk), .reset (reset), .bus (b1.slave));
  fnv_hasher #(.HASH_W(64), .VARIANT(0), .CNT_W(16)) dut_s2 (.clk (clk), .reset (reset), .bus (b2.slave));
  assign b0.in_valid = sv;  assign b0.in_data = 8'h61;  assign b0.in_last = 1'b1;  assign b0.out_ready = sr;
  assign b1.in_valid = sv;  assign b1.in_data = 8'h61;  assign b1.in_last = 1'b1;  assign b1.out_ready = sr;
  assign b2.in_valid = sv;  assign b2.in_data = 8'h61;  assign b2.in_last = 1'b1;  assign b2.out_ready = sr;

  typedef struct {
    string       msg;
    logic [31:0] exp;
    int          gap_max;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] hash;
    logic [3:0]  count;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_1a32(input byte unsigned m[$]);
    logic [31:0] h;
    h = 32'h811C_9DC5;
    foreach (m[i]) h = (h ^ {24'h0, m[i]}) * 32'h0100_0193;
    return h;
  endfunction

  // Drive one message; the expected digest is queued with the last byte.
  task automatic send_msg(input byte unsigned m[$], input logic [31:0] exp_h, input int gap_max);
    exp_t e;
    int   n;
    for (int i = 0; i < m.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = (i == m.size() - 1);
      if (bus.in_last) begin
        e.hash  = exp_h;
        e.count = (m.size() > 15) ? 4'hF : 4'(m.size());
        sb.push_back(e);
      end
      n = 0;
      while (!bus.in_ready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) check("in_ready_timeout", 64'd0, 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  // Called right after the final byte's accepting edge.
  task automatic collect(input int hold, input string name);
    exp_t e;
    int   n;
    logic [31:0] h0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      check({name, "_stall"}, {62'd0, bus.in_ready, bus.busy}, 64'd1);
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      check({name, "_out_valid_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({name, "_latency"}, 64'(n), 64'd4);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({name, "_hash"}, 64'(bus.out_hash), 64'(e.hash));
    check({name, "_count"}, 64'(bus.out_count), 64'(e.count));
`ifdef FNV_XOR_FOLD_EN
    check({name, "_fold"}, 64'(bus.out_fold), 64'(e.hash[31:16] ^ e.hash[15:0]));
`endif
    h0 = bus.out_hash;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bus.out_valid || bus.out_hash !== h0 || bus.in_ready)
        check({name, "_hold"}, {31'd0, bus.out_valid, bus.out_hash}, {31'd1, h0});
    end
    if (hold > 0) check({name, "_held_hash"}, 64'(bus.out_hash), 64'(e.hash));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_post_hs"}, {bus.out_hash, 26'd0, bus.out_count, bus.out_valid, bus.in_ready},
          {32'h811C_9DC5, 26'd0, 4'd0, 1'b0, 1'b1});
  endtask

  vec_t          tbl[5];
  byte unsigned  q[$];
  int            lat[3];
  logic [63:0]   sh[3];

  initial begin
    tbl[0] = '{msg: "a",      exp: 32'hE40C_292C, gap_max: 0, hold: 0};
    tbl[1] = '{msg: "b",      exp: 32'hE70C_2DE5, gap_max: 0, hold: 2};
    tbl[2] = '{msg: "fo",     exp: 32'h6222_E842, gap_max: 2, hold: 0};
    tbl[3] = '{msg: "foo",    exp: 32'hA9F3_7ED7, gap_max: 0, hold: 1};
    tbl[4] = '{msg: "foobar", exp: 32'hBF9C_F968, gap_max: 4, hold: 10};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    sv = 1'b0; sr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_state", {bus.out_hash, 26'd0, bus.out_count, bus.out_valid, bus.in_ready, bus.busy},
          {32'h811C_9DC5, 26'd0, 4'd0, 1'b0, 1'b1, 1'b0});
    check("reset_s1_hash", b1.out_hash, 64'hCBF2_9CE4_8422_2325);

    foreach (tbl[i]) begin
      q.delete();
      for (int j = 0; j < tbl[i].msg.len(); j++) q.push_back(tbl[i].msg[j]);
      send_msg(q, tbl[i].exp, tbl[i].gap_max);
      collect(tbl[i].hold, tbl[i].msg);
    end

    // Reset while the multiplier is on step 2 of a non-final byte.
    bus.in_valid = 1'b1; bus.in_data = 8'h7A; bus.in_last = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_mul_reset", {bus.out_hash, 26'd0, bus.out_count, bus.out_valid, bus.in_ready, bus.busy},
          {32'h811C_9DC5, 26'd0, 4'd0, 1'b0, 1'b1, 1'b0});
    q.delete();
    q.push_back(8'h61);
    send_msg(q, 32'hE40C_292C, 0);
    collect(0, "after_reset_a");

    // Long random message: counter saturates at all-ones.
    q.delete();
    for (int j = 0; j < 20; j++) q.push_back(8'($urandom_range(0, 255)));
    send_msg(q, model_1a32(q), 1);
    collect(3, "saturate");

    // Side instances: one "a" byte each, latency measured from the accept edge.
    lat = '{-1, -1, -1};
    sv = 1'b1;
    tick();
    sv = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (b0.out_valid && lat[0] < 0) begin lat[0] = n; sh[0] = 64'(b0.out_hash); end
      if (b1.out_valid && lat[1] < 0) begin lat[1] = n; sh[1] = b1.out_hash; end
      if (b2.out_valid && lat[2] < 0) begin lat[2] = n; sh[2] = b2.out_hash; end
    end
    check("fnv1_32_latency",  64'(lat[0]), 64'd4);
    check("fnv1a_64_latency", 64'(lat[1]), 64'd8);
    check("fnv1_64_latency",  64'(lat[2]), 64'd8);
    check("fnv1_32_hash",  sh[0], 64'h0000_0000_050C_5D7E);
    check("fnv1a_64_hash", sh[1], 64'hAF63_DC4C_8601_EC8C);
    check("fnv1_64_hash",  sh[2], 64'hAF63_BD4C_8601_B7BE);
    check("fnv1_64_count", 64'(b2.out_count), 64'd1);
    check("fnv1_64_held",  b2.out_hash, 64'hAF63_BD4C_8601_B7BE);
    sr = 1'b1;
    tick();
    sr = 1'b0;
    check("side_post_hs", {b1.out_hash, 61'd0, b0.out_valid, b1.out_valid, b2.out_valid},
          {64'hCBF2_9CE4_8422_2325, 64'd0});

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
